// File: rtl/dcache_direct.sv
`default_nettype none
// ============================================================================
// Module      : dcache_direct
// Description : Direct-mapped, write-through, no-write-allocate data cache
//               between the MEM stage and a 32-bit word memory. A read miss
//               refills the whole line over WORDS cycles. A store is written
//               through to memory in a single WRITE cycle, and the cache copy
//               is updated only on a hit. Hit and miss counters saturate.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_direct #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic        mem_wmem,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] K_LAST = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Per-line storage
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS];

  // Refill bookkeeping; tag/index are latched so the refill is self-contained
  logic [OFF_W-1:0] k_q;
  logic [TAG_W-1:0] rtag_q;
  logic [IDX_W-1:0] ridx_q;
  logic             refilled_q;
  logic [31:0]      hit_cnt_q;
  logic [31:0]      miss_cnt_q;

  // Address decomposition of the current request
  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;

  // Event strobes produced by the FSM decode
  logic load_hit;
  logic load_miss;
  logic refill_we;
  logic refill_last;
  logic store_we;

  assign off = cpu_addr[OFF_W+1:2];
  assign idx = cpu_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign tag = cpu_addr[31:IDX_W+OFF_W+2];
  assign hit = cpu_req & valid_q[idx] & (tag_q[idx] == tag);

  assign mem_wdata  = cpu_wdata;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  // Next-state, CPU/memory outputs and update strobes
  always_comb begin
    state_d     = state_q;
    cpu_stall   = 1'b0;
    cpu_rdata   = 32'd0;
    mem_addr    = cpu_addr;
    mem_wmem    = 1'b0;
    load_hit    = 1'b0;
    load_miss   = 1'b0;
    refill_we   = 1'b0;
    refill_last = 1'b0;
    store_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            cpu_stall = 1'b1;
            state_d   = WRITE;
          end else if (hit) begin
            cpu_rdata = data_q[idx][off];
            load_hit  = 1'b1;
          end else begin
            cpu_stall = 1'b1;
            load_miss = 1'b1;
            state_d   = REFILL;
          end
        end
      end
      REFILL: begin
        cpu_stall = 1'b1;
        mem_addr  = {rtag_q, ridx_q, k_q, 2'b00};
        refill_we = 1'b1;
        if (k_q == K_LAST) begin
          refill_last = 1'b1;
          state_d     = IDLE;
        end
      end
      WRITE: begin
        mem_wmem = 1'b1;
        store_we = hit & cpu_we;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // No memory write may escape during a reset cycle
    if (reset) begin
      mem_wmem = 1'b0;
      store_we = 1'b0;
    end
  end

  // Control state: FSM, valid bits, refill counter, statistics
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      k_q        <= '0;
      rtag_q     <= '0;
      ridx_q     <= '0;
      refilled_q <= 1'b0;
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (load_miss) begin
        k_q          <= '0;
        rtag_q       <= tag;
        ridx_q       <= idx;
        valid_q[idx] <= 1'b0;
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if (refill_we) begin
        k_q <= k_q + 1'b1;
        if (refill_last) begin
          valid_q[ridx_q] <= 1'b1;
          refilled_q      <= 1'b1;
        end
      end
      if (load_hit) begin
        refilled_q <= 1'b0;
        if (!refilled_q && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end
    end
  end

  // Tag and data arrays: refill fills word k, store hits update in place
  always_ff @(posedge clock) begin
    if (refill_we) begin
      data_q[ridx_q][k_q] <= mem_rdata;
      if (refill_last) tag_q[ridx_q] <= rtag_q;
    end
    if (store_we) data_q[idx][off] <= cpu_wdata;
  end

endmodule
`default_nettype wire
